// File: rtl/mobo_mem_arbiter_if.sv
// Channel request/ack bus plus RAM port of the motherboard memory arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
`ifndef RAM_READY_PIN
`define RAM_READY_PIN 0
`endif
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 0
`endif
`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 1
`endif

interface mobo_mem_arbiter_if #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int AW  = 32
);
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_we;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_ack;
  logic [NCH-1:0]    ch_err;
  logic [DW-1:0]     ch_rdata;
  logic [31:0]       ram_ctrl_in;
  logic [31:0]       ram_ctrl_out;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     data_in;
  logic [DW-1:0]     data_out;

  modport master (
    output ch_req, ch_we, ch_addr, ch_wdata, ram_ctrl_in, data_in,
    input  ch_ack, ch_err, ch_rdata, ram_ctrl_out, addr, data_out
  );

  modport slave (
    input  ch_req, ch_we, ch_addr, ch_wdata, ram_ctrl_in, data_in,
    output ch_ack, ch_err, ch_rdata, ram_ctrl_out, addr, data_out
  );
endinterface

// File: rtl/mobo_mem_arbiter.sv
// Round-robin arbiter of NCH requesters onto one RAM port (IDLE->ISSUE->WAIT->DONE).
// Optional MOBO_ARB_TIMEOUT_EN: abort WAIT after TMO cycles with ack+err.
`ifndef RAM_READY_PIN
`define RAM_READY_PIN 0
`endif
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 0
`endif
`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 1
`endif

module mobo_mem_arbiter #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int TMO = 64
) (
  input  logic               clk,
  input  logic               rst,
  mobo_mem_arbiter_if.slave  bus
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   gnt_r;
  logic            we_r;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   data_out_r;
  logic [DW-1:0]   ch_rdata_r;
  logic [31:0]     ram_ctrl_out_r;
  logic [NCH-1:0]  ch_ack_r;

  logic            grant_vld_s;
  logic [PW-1:0]   grant_idx_s;
  logic [PW:0]     cand_s;
  logic            ready_s;
  logic            unused_s;

`ifdef MOBO_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;
  logic [CW-1:0]   tmo_cnt_r;
  logic [NCH-1:0]  ch_err_r;
`endif

  // Exactly one of the read/write strobe bits, selected by the transfer direction.
  function automatic logic [31:0] strobe_word(input logic we);
    logic [31:0] w;
    w = 32'h0000_0000;
    if (we) begin
      w[`RAM_WRITE_PIN] = 1'b1;
    end else begin
      w[`RAM_READ_PIN] = 1'b1;
    end
    return w;
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [PW-1:0] idx);
    logic [NCH-1:0] v;
    v = {NCH{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  assign ready_s  = bus.ram_ctrl_in[`RAM_READY_PIN];
  assign unused_s = ^{bus.ram_ctrl_in, 32'(TMO)};

  // First requester at or after ptr, wrapping modulo NCH.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {PW{1'b0}};
    cand_s      = {(PW+1){1'b0}};
    for (int k = 0; k < NCH; k++) begin
      cand_s      = {1'b0, ptr_r} + (PW+1)'(k);
      cand_s      = (cand_s >= (PW+1)'(NCH)) ? cand_s - (PW+1)'(NCH) : cand_s;
      grant_idx_s = (!grant_vld_s && bus.ch_req[cand_s[PW-1:0]]) ? cand_s[PW-1:0] : grant_idx_s;
      grant_vld_s = grant_vld_s | bus.ch_req[cand_s[PW-1:0]];
    end
  end

  // Transaction FSM; every port-visible output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      ptr_r          <= {PW{1'b0}};
      gnt_r          <= {PW{1'b0}};
      we_r           <= 1'b0;
      addr_r         <= {AW{1'b0}};
      data_out_r     <= {DW{1'b0}};
      ch_rdata_r     <= {DW{1'b0}};
      ram_ctrl_out_r <= 32'h0000_0000;
      ch_ack_r       <= {NCH{1'b0}};
`ifdef MOBO_ARB_TIMEOUT_EN
      tmo_cnt_r      <= {CW{1'b0}};
      ch_err_r       <= {NCH{1'b0}};
`endif
    end else begin
      ch_ack_r <= {NCH{1'b0}};
`ifdef MOBO_ARB_TIMEOUT_EN
      ch_err_r <= {NCH{1'b0}};
`endif
      case (state_r)
        ST_IDLE: begin
          if (grant_vld_s) begin
            gnt_r          <= grant_idx_s;
            we_r           <= bus.ch_we[grant_idx_s];
            addr_r         <= bus.ch_addr[grant_idx_s*AW +: AW];
            data_out_r     <= bus.ch_wdata[grant_idx_s*DW +: DW];
            ram_ctrl_out_r <= strobe_word(bus.ch_we[grant_idx_s]);
            state_r        <= ST_ISSUE;
          end else begin
            state_r        <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
`ifdef MOBO_ARB_TIMEOUT_EN
          tmo_cnt_r <= {CW{1'b0}};
`endif
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ready_s) begin
            if (!we_r) begin
              ch_rdata_r <= bus.data_in;
            end else begin
              ch_rdata_r <= ch_rdata_r;
            end
            ram_ctrl_out_r <= 32'h0000_0000;
            ch_ack_r       <= onehot(gnt_r);
            state_r        <= ST_DONE;
`ifdef MOBO_ARB_TIMEOUT_EN
          end else if (tmo_cnt_r == CW'(TMO - 1)) begin
            ram_ctrl_out_r <= 32'h0000_0000;
            ch_ack_r       <= onehot(gnt_r);
            ch_err_r       <= onehot(gnt_r);
            state_r        <= ST_DONE;
          end else begin
            tmo_cnt_r      <= tmo_cnt_r + CW'(1);
`else
          end else begin
`endif
            state_r        <= ST_WAIT;
          end
        end
        ST_DONE: begin
          // The served channel becomes lowest priority for the next search.
          ptr_r   <= (gnt_r == PW'(NCH - 1)) ? {PW{1'b0}} : gnt_r + PW'(1);
          state_r <= ST_IDLE;
        end
        default: begin
          ram_ctrl_out_r <= 32'h0000_0000;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ch_ack       = ch_ack_r;
  assign bus.ch_rdata     = ch_rdata_r;
  assign bus.ram_ctrl_out = ram_ctrl_out_r;
  assign bus.addr         = addr_r;
  assign bus.data_out     = data_out_r;
`ifdef MOBO_ARB_TIMEOUT_EN
  assign bus.ch_err       = ch_err_r;
`else
  assign bus.ch_err       = {NCH{1'b0}};
`endif

endmodule

// File: tb/tb_mobo_mem_arbiter.sv
// Directed self-checking bench for mobo_mem_arbiter with a simple ready-delay RAM model.
`ifndef RAM_READY_PIN
`define RAM_READY_PIN 0
`endif
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 0
`endif
`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 1
`endif

module tb_mobo_mem_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 64;
  localparam int RD  = `RAM_READ_PIN;
  localparam int WR  = `RAM_WRITE_PIN;
  localparam int RDY = `RAM_READY_PIN;

  logic        clk = 1'b0;
  logic        rst;
  int          check_cnt = 0;
  int          err_cnt   = 0;
  int          ram_wait  = 1;
  bit          ready_en  = 1'b0;
  logic [31:0] ram_rdata = 32'h0;
  int          strobe_cnt = 0;

  mobo_mem_arbiter_if #(.NCH(NCH), .DW(DW), .AW(AW)) bus ();

  mobo_mem_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // RAM answers once the strobe has been up for ram_wait cycles beyond ISSUE.
  always @(negedge clk) begin
    if (bus.ram_ctrl_out[RD] || bus.ram_ctrl_out[WR]) strobe_cnt = strobe_cnt + 1;
    else strobe_cnt = 0;
    bus.ram_ctrl_in      = 32'h0;
    bus.ram_ctrl_in[RDY] = ready_en && (strobe_cnt > ram_wait);
    bus.data_in          = ram_rdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ch_we[ch]              = we;
    bus.ch_addr[ch*AW +: AW]   = a;
    bus.ch_wdata[ch*DW +: DW]  = d;
    bus.ch_req[ch]             = 1'b1;
  endtask

  // Steps negedges until an ack appears or the budget runs out.
  task automatic wait_ack(input int budget, output int ncyc, output logic [NCH-1:0] ack,
                          output logic [NCH-1:0] err, output int rd_hi, output int wr_hi,
                          output logic [AW-1:0] a0, output logic [DW-1:0] d0);
    ncyc = 0; rd_hi = 0; wr_hi = 0; ack = '0; err = '0; a0 = '0; d0 = '0;
    while (ncyc < budget && ack == '0) begin
      @(negedge clk);
      ncyc++;
      if ((bus.ram_ctrl_out[RD] || bus.ram_ctrl_out[WR]) && (rd_hi + wr_hi == 0)) begin
        a0 = bus.addr;
        d0 = bus.data_out;
      end
      rd_hi += int'(bus.ram_ctrl_out[RD]);
      wr_hi += int'(bus.ram_ctrl_out[WR]);
      ack = bus.ch_ack;
      err = bus.ch_err;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int             n, rh, wh;
    logic [NCH-1:0] a, e, acc, exp_ack;
    logic [AW-1:0]  ad;
    logic [DW-1:0]  dd;

    rst          = 1'b0;
    bus.ch_req   = '0;
    bus.ch_we    = '0;
    bus.ch_addr  = '0;
    bus.ch_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ctrl",  bus.ram_ctrl_out, 32'h0);
    check("rst_addr",  bus.addr, 32'h0);
    check("rst_dout",  bus.data_out, 32'h0);
    check("rst_ack",   bus.ch_ack, 4'h0);
    check("rst_err",   bus.ch_err, 4'h0);
    check("rst_rdata", bus.ch_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single read on ch1, two WAIT cycles
    ram_wait = 2; ready_en = 1'b1; ram_rdata = 32'hDEADBEEF;
    set_ch(1, 1'b0, 32'h100, 32'h0);
    wait_ack(20, n, a, e, rh, wh, ad, dd);
    check("rd_ack",   a, 4'b0010);
    check("rd_lat",   n, 4);
    check("rd_pin",   rh, 3);
    check("rd_nowr",  wh, 0);
    check("rd_addr",  ad, 32'h100);
    check("rd_data",  bus.ch_rdata, 32'hDEADBEEF);
    bus.ch_req[1] = 1'b0;
    @(negedge clk);
    check("rd_pulse", bus.ch_ack, 4'h0);

    // Single write on ch0, immediate ready; rdata must not change
    ram_wait = 1; ram_rdata = 32'hCAFEF00D;
    set_ch(0, 1'b1, 32'h20, 32'h12345678);
    wait_ack(20, n, a, e, rh, wh, ad, dd);
    check("wr_ack",   a, 4'b0001);
    check("wr_lat",   n, 3);
    check("wr_pin",   wh, 2);
    check("wr_nord",  rh, 0);
    check("wr_addr",  ad, 32'h20);
    check("wr_dout",  dd, 32'h12345678);
    check("wr_rdata", bus.ch_rdata, 32'hDEADBEEF);
    bus.ch_req[0] = 1'b0;
    @(negedge clk);

    // Reset in the middle of WAIT aborts without ack
    ready_en = 1'b0;
    set_ch(2, 1'b0, 32'h300, 32'h0);
    repeat (4) @(negedge clk);
    check("mid_wait_strobe", bus.ram_ctrl_out[RD], 1'b1);
    rst = 1'b0;
    #1;
    check("arst_ctrl",  bus.ram_ctrl_out, 32'h0);
    check("arst_addr",  bus.addr, 32'h0);
    check("arst_dout",  bus.data_out, 32'h0);
    check("arst_rdata", bus.ch_rdata, 32'h0);
    check("arst_ack",   bus.ch_ack, 4'h0);
    bus.ch_req = '0;
    @(negedge clk);
    rst = 1'b1;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc = acc | bus.ch_ack;
    end
    check("arst_no_ack", acc, 4'h0);
    check("arst_idle",   bus.ram_ctrl_out, 32'h0);

    // All four requesting continuously: grants 0,1,2,3,0 four cycles apart
    ram_wait = 1; ready_en = 1'b1; ram_rdata = 32'hA5A50000;
    for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, 32'(c * 16), 32'h0);
    for (int i = 0; i < 5; i++) begin
      exp_ack = 4'b0001 << (i % NCH);
      wait_ack(20, n, a, e, rh, wh, ad, dd);
      check("rr_ack",  a, exp_ack);
      check("rr_gap",  n, (i == 0) ? 3 : 4);
      check("rr_addr", ad, 32'((i % NCH) * 16));
    end
    check("rr_rdata", bus.ch_rdata, 32'hA5A50000);
    bus.ch_req = '0;
    @(negedge clk);

    // Move ptr to 3, then ch0+ch3 together: ch3 first, then ch0
    set_ch(2, 1'b0, 32'h500, 32'h0);
    wait_ack(20, n, a, e, rh, wh, ad, dd);
    check("pre_wrap_ack", a, 4'b0100);
    bus.ch_req[2] = 1'b0;
    @(negedge clk);
    set_ch(0, 1'b0, 32'h40, 32'h0);
    set_ch(3, 1'b0, 32'h70, 32'h0);
    wait_ack(20, n, a, e, rh, wh, ad, dd);
    check("wrap_first", a, 4'b1000);
    bus.ch_req[3] = 1'b0;
    wait_ack(20, n, a, e, rh, wh, ad, dd);
    check("wrap_second", a, 4'b0001);
    check("wrap_gap",    n, 4);
    bus.ch_req[0] = 1'b0;
    @(negedge clk);

    // RAM never ready
    ready_en = 1'b0;
    set_ch(1, 1'b0, 32'h600, 32'h0);
`ifdef MOBO_ARB_TIMEOUT_EN
    wait_ack(100, n, a, e, rh, wh, ad, dd);
    check("tmo_ack",   a, 4'b0010);
    check("tmo_err",   e, 4'b0010);
    check("tmo_lat",   n, 66);
    check("tmo_pin",   rh, 65);
    check("tmo_rdata", bus.ch_rdata, 32'hA5A50000);
    bus.ch_req[1] = 1'b0;
    @(negedge clk);
    check("tmo_err_pulse", bus.ch_err, 4'h0);
`else
    wait_ack(200, n, a, e, rh, wh, ad, dd);
    check("hang_no_ack",   a, 4'h0);
    check("hang_no_err",   e, 4'h0);
    check("hang_in_wait",  bus.ram_ctrl_out[RD], 1'b1);
    ram_wait = 1; ready_en = 1'b1;
    wait_ack(10, n, a, e, rh, wh, ad, dd);
    check("hang_recover",  a, 4'b0010);
    check("hang_rec_err",  e, 4'h0);
    bus.ch_req[1] = 1'b0;
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
